// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-port SPI arbiter.
package spi_arb_pkg;

   // Arbiter sequencing: wait for a request, strobe the master, wait for it, answer the owner
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   localparam int DEF_TIMEOUT = 4096;
   localparam int DEF_GAP     = 4;

   // Round-robin pick: a lone requester wins, a tie goes to the port that was not granted last.
   // Returns the winning port index (0 or 1).
   function automatic logic pick_port(input logic r0, input logic r1, input logic last);
      return (r0 && (!r1 || last)) ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/spi_arb_tmr.sv
// Watchdog up-counter and inter-transaction gap down-counter for spi_arb.
module spi_arb_tmr
   import spi_arb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GAP     = DEF_GAP
) (
   input  logic clk,
   input  logic rst,
   input  logic wd_clear,
   input  logic wd_run,
   input  logic gap_load,
   input  logic gap_run,
   output logic wd_expired,
   output logic gap_zero
);

   localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP);

   logic [WD_W-1:0]  wd;
   logic [GAP_W-1:0] gap;

   // Watchdog: zeroed at grant so it reads 0 in the strobe cycle, then counts every cycle of the transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         wd <= '0;
      end else if (wd_clear) begin
         wd <= '0;
      end else if (wd_run) begin
         wd <= wd + WD_W'(1);
      end
   end

   // Gap counter: loaded when a response is issued, drains to zero while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         gap <= '0;
      end else if (gap_load) begin
         gap <= GAP_INIT;
      end else if (gap_run && (gap != '0)) begin
         gap <= gap - GAP_W'(1);
      end
   end

   assign wd_expired = (wd == WD_LAST);
   assign gap_zero   = (gap == '0);

endmodule

// File: rtl/spi_arb.sv
// Two-port round-robin arbiter in front of a single SPI master, with watchdog abort and SS_n gap.
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int GAP     = DEF_GAP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] cmd0,
   input  logic [15:0] cmd1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] rd_data,
   output logic        err,
   output logic        busy,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data
);

   arb_state_e state;
   logic       owner;
   logic       last_grant;
   logic       grant;
   logic       winner;
   logic       wd_expired;
   logic       gap_zero;

   assign grant   = (state == IDLE) && gap_zero && (req0 || req1);
   assign winner  = pick_port(req0, req1, last_grant);
   assign spi_wrt = (state == LAUNCH);
   assign busy    = (state != IDLE);

   spi_arb_tmr #(
      .TIMEOUT (TIMEOUT),
      .GAP     (GAP)
   ) u_tmr (
      .clk        (clk),
      .rst        (rst),
      .wd_clear   (grant),
      .wd_run     ((state == LAUNCH) || (state == BUSY)),
      .gap_load   (state == RESP),
      .gap_run    (state == IDLE),
      .wd_expired (wd_expired),
      .gap_zero   (gap_zero)
   );

   // Arbitration FSM with registered command, response data, error flag and completion pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         spi_cmd    <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         rd_data    <= '0;
         err        <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner   <= winner;
                  spi_cmd <= winner ? cmd1 : cmd0;
                  state   <= LAUNCH;
               end
            end
            LAUNCH: begin
               state <= BUSY;
            end
            BUSY: begin
               if (spi_done) begin
                  rd_data <= spi_rd_data;
                  err     <= 1'b0;
                  done0   <= ~owner;
                  done1   <= owner;
                  state   <= RESP;
               end else if (wd_expired) begin
                  rd_data <= 16'h0000;
                  err     <= 1'b1;
                  done0   <= ~owner;
                  done1   <= owner;
                  state   <= RESP;
               end
            end
            RESP: begin
               last_grant <= owner;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
